mac_accumulator: RTL

Sequential multiply-accumulate stage directly downstream of the 4-bit array multiplier (`top_array_multiplier`). It accepts a stream of 4-bit operand pairs over a valid/ready handshake and feeds each pair to an internal `top_array_multiplier` instance. Each 8-bit product is registered, and N consecutive products are summed into a widened accumulator. The final sum is presented on a valid/ready output port, so the combinational multiplier array can be used in dot-product and filter paths.

---
 rtl/mac_accumulator_pkg.sv | 19 +
 rtl/mac_accumulator_mult.sv | 20 ++
 rtl/mac_accumulator.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mac_accumulator_pkg.sv
// Shared types and sizing helpers for the multiply-accumulate stage.
package mac_pkg;

  // Accumulator control states.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Width of one 4x4 unsigned product.
  localparam int PROD_W = 8;

  // Smallest accumulator that holds n full-scale products without wrapping.
  function automatic int acc_width(input int n);
    return PROD_W + $clog2(n);
  endfunction

endpackage

// File: rtl/mac_accumulator_mult.sv
// Combinational 4x4 unsigned array multiplier: AND-gated partial products,
// each shifted by its multiplier bit position, summed into an 8-bit result.
module top_array_multiplier
  import mac_pkg::*;
(
  input  logic [3:0]        A,
  input  logic [3:0]        B,
  output logic [PROD_W-1:0] P
);

  logic [PROD_W-1:0] pp [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_pp
    assign pp[gi] = ({4'd0, A} & {PROD_W{B[gi]}}) << gi;
  end

  // Largest product is 15*15 = 225, so the 8-bit sum never truncates.
  assign P = pp[0] + pp[1] + pp[2] + pp[3];

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage: takes N operand pairs over valid/ready, registers
// each product, sums them and offers the total on a valid/ready output.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = acc_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  localparam int CNT_W = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic              prod_v_q, prod_v_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [ACC_W-1:0]  out_sum_q;
  logic [PROD_W-1:0] mult_p;
  logic              accept_s;
  logic              handoff_s;

  top_array_multiplier u_mult (
    .A (in_a),
    .B (in_b),
    .P (mult_p)
  );

  // in_ready depends only on state and reset, never on in_valid/out_ready.
  assign in_ready  = !rst && (state_q == ACCUM);
  assign accept_s  = in_valid && (state_q == ACCUM);
  assign handoff_s = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

  // Next-state, product capture and accumulation decisions.
  always_comb begin
    state_d     = state_q;
    prod_d      = prod_q;
    prod_v_d    = 1'b0;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    // Accumulation runs in every state whenever a product is pending.
    if (prod_v_q) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      ACCUM: begin
        if (accept_s) begin
          prod_d     = mult_p;
          prod_v_d   = 1'b1;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(N - 1)) begin
            state_d = DRAIN;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          prod_v_d = 1'b0;
        end
      end
      DRAIN: begin
        // The last product lands in acc on this edge; result is then complete.
        state_d     = DONE;
        out_valid_d = 1'b1;
      end
      DONE: begin
        if (handoff_s) begin
          acc_d       = '0;
          beat_cnt_d  = '0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = ACCUM;
        acc_d       = '0;
        beat_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      beat_cnt_q  <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      // out_sum mirrors acc; it is stable in DONE because nothing is pending.
      out_sum_q   <= acc_d;
    end
  end

endmodule
